// File: rtl/a429_tx_sched.sv
`default_nettype none
//==============================================================================
// Module      : a429_tx_sched
// Description : Round-robin scheduler in front of a single ARINC 429 bipolar
//               return-to-zero transmitter. NUM_REQ requesters offer 32-bit
//               words; one is granted per idle slot, serialised LSB first on
//               the HI/LO line-driver legs, then followed by a null gap.
// Ports       : clk        - system clock, rising edge
//               rst_n      - asynchronous active-low reset
//               tx_en      - permits new grants (word in flight always finishes)
//               req_valid  - per-requester word-available flags
//               req_data   - packed words, requester i at [32*i+31:32*i]
//               req_ready  - one-cycle accept pulse to the granted requester
//               tx_hi      - HI leg of the line driver
//               tx_lo      - LO leg of the line driver
//               busy       - word or inter-word gap in progress
//               grant_id   - requester index of the current/last word
// Revision    : 1.0 - initial release
//==============================================================================
module a429_tx_sched #(
    parameter int NUM_REQ    = 4,
    parameter int CLK_DIV    = 250,
    parameter int GAP_BITS   = 4,
    parameter int PARITY_GEN = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tx_en,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [32*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx_hi,
    output logic                   tx_lo,
    output logic                   busy,
    output logic [2:0]             grant_id
);

    localparam int HW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_LEN = GAP_BITS * 2 * CLK_DIV;
    localparam int GW      = $clog2(GAP_LEN);
    localparam int PW      = $clog2(NUM_REQ);

    localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_LEN - 1);
    localparam logic [4:0]    BIT_LAST  = 5'd31;
    localparam logic [PW-1:0] REQ_LAST  = PW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   word_q,  word_d;
    logic [4:0]    bit_q,   bit_d;
    logic [HW-1:0] half_q,  half_d;
    logic          phase_q, phase_d;    // 0: active half of the bit, 1: null half
    logic [GW-1:0] gap_q,   gap_d;
    logic [PW-1:0] ptr_q,   ptr_d;      // round-robin search start
    logic [2:0]    grant_q, grant_d;
    logic          tx_hi_q, tx_hi_d;
    logic          tx_lo_q, tx_lo_d;

    logic          w_sel_found;
    logic [PW-1:0] w_sel_idx;
    logic [31:0]   w_sel_word;
    logic [31:0]   w_tx_word;

    // Requester index 'offs' positions after 'base', wrapping at NUM_REQ.
    function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int offs);
        int s;
        s = int'(base) + offs;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return PW'(s);
    endfunction

    // Scanning from the far end lets the nearest valid requester overwrite
    // any farther one, so the first hit after the pointer wins.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[rr_index(ptr_q, k)]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = rr_index(ptr_q, k);
            end
        end
    end

    assign w_sel_word = req_data[{w_sel_idx, 5'b00000} +: 32];

    // Odd parity: bit 31 is set when bits 30:0 hold an even number of ones.
    assign w_tx_word = (PARITY_GEN != 0) ? {~^w_sel_word[30:0], w_sel_word[30:0]}
                                         : w_sel_word;

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        bit_d     = bit_q;
        half_d    = half_q;
        phase_d   = phase_q;
        gap_d     = gap_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        tx_hi_d   = 1'b0;
        tx_lo_d   = 1'b0;
        req_ready = '0;

        case (state_q)
            IDLE: begin
                bit_d   = '0;
                half_d  = '0;
                phase_d = 1'b0;
                gap_d   = '0;
                // rst_n gating keeps the accept pulse quiet while reset is held.
                if (tx_en && w_sel_found && rst_n) begin
                    req_ready[w_sel_idx] = 1'b1;
                    word_d  = w_tx_word;
                    grant_d = 3'(w_sel_idx);
                    ptr_d   = (w_sel_idx == REQ_LAST) ? '0 : w_sel_idx + PW'(1);
                    state_d = SEND;
                    // Bit 0 goes on the line in the very next cycle.
                    tx_hi_d = w_tx_word[0];
                    tx_lo_d = ~w_tx_word[0];
                end
            end

            SEND: begin
                tx_hi_d = tx_hi_q;
                tx_lo_d = tx_lo_q;
                if (half_q == HALF_LAST) begin
                    half_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        tx_hi_d = 1'b0;
                        tx_lo_d = 1'b0;
                    end else begin
                        phase_d = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            bit_d   = '0;
                            state_d = GAP;
                            tx_hi_d = 1'b0;
                            tx_lo_d = 1'b0;
                        end else begin
                            bit_d   = bit_q + 5'd1;
                            tx_hi_d = word_q[bit_d];
                            tx_lo_d = ~word_q[bit_d];
                        end
                    end
                end else begin
                    half_d = half_q + HW'(1);
                end
            end

            GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            bit_q   <= '0;
            half_q  <= '0;
            phase_q <= 1'b0;
            gap_q   <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            tx_hi_q <= 1'b0;
            tx_lo_q <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            bit_q   <= bit_d;
            half_q  <= half_d;
            phase_q <= phase_d;
            gap_q   <= gap_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            tx_hi_q <= tx_hi_d;
            tx_lo_q <= tx_lo_d;
        end
    end

    assign tx_hi    = tx_hi_q;
    assign tx_lo    = tx_lo_q;
    assign busy     = (state_q != IDLE);
    assign grant_id = grant_q;

endmodule
`default_nettype wire
